vol_led_meter: RTL and testbench
================================

# vol_led_meter

Parametrised volume bar-graph driver with peak hold, decay and PWM dimming. It sits between the volume controller and the board LED bank. It converts a captured volume/attenuation level into an N-LED bar or dot pattern, marks a held peak LED, and dims the bar through a free-running PWM. All outputs are registered.

## Interface
- N_LED, 8, number of LEDs driven.
- LVL_W, 5, width of the input level.
- HOLD_CYC, 25_000_000, cycles the peak is held after its last refresh (≥1).
- DECAY_CYC, 2_500_000, cycles per one-step peak decrement (≥1).
- PWM_W, 4, brightness/PWM counter width.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_level  in  LVL_W  volume (or attenuation when i_invert=1).
- i_level_vld  in  1  capture strobe for i_level, one cycle.
- i_invert  in  1  1: level is attenuation, displayed value is N_LED−i_level.
- i_mode  in  1  0 bar, 1 dot.
- i_peak_en  in  1  enables peak hold/decay.
- i_bright  in  PWM_W  bar brightness; all-ones = always on.
- o_vol_led  out  N_LED  LED pattern, bit 0 = lowest LED.
- o_peak  out  clog2(N_LED+1)  current peak level.

## Operation
- Effective level eff is computed at capture and saturates to 0..N_LED:
  - i_invert=0: eff = min(i_level, N_LED).
  - i_invert=1: eff = 0 if i_level ≥ N_LED, else N_LED−i_level.
  - Subtraction and compare are done at LVL_W+1 bits, with no wrap.
- cur_lvl is loaded with eff on i_level_vld. It holds otherwise.
- Peak FSM has three states: IDLE (peak==cur_lvl), HOLD, DECAY. One down-counter is shared between HOLD and DECAY.
- On capture with eff ≥ peak: peak←eff, counter←HOLD_CYC−1, state HOLD. This applies from any state, including DECAY.
- On capture with eff < peak: peak and counter are unchanged. The exception is IDLE, which goes to HOLD with the counter reloaded to HOLD_CYC−1.
- HOLD: the counter decrements each cycle. When it reaches 0: state DECAY, counter←DECAY_CYC−1.
- DECAY: when the counter reaches 0: peak←max(peak−1, cur_lvl) and the counter reloads. If the new peak equals cur_lvl, the state goes to IDLE.
- i_peak_en=0 forces peak←cur_lvl (tracking the new cur_lvl on a capture cycle) and state IDLE every cycle.
- PWM: pwm_cnt is PWM_W bits and free-running. pwm_on = (i_bright == all-ones) | (pwm_cnt < i_bright).
- Bar mode: bit k is set iff k < cur_lvl and pwm_on.
- Dot mode: only bit cur_lvl−1 is set (when cur_lvl>0), gated by pwm_on.
- Peak marker: when i_peak_en, peak>cur_lvl and peak>0, bit peak−1 is forced to 1, ungated by PWM.
- Pattern is OR of level pattern and peak marker.

## Timing
- Reset (async assert) sets:
  - o_vol_led=0, o_peak=0.
  - cur_lvl=0, peak=0, counter=0, pwm_cnt=0, state IDLE.
- Outputs clear immediately on rst_n low, with no clock needed.
- Release is synchronous to the next clk edge.
- Latency:
  - Capture at edge E updates cur_lvl, peak and o_peak at E.
  - o_vol_led reflects it at E+1, a one-cycle register stage.
- Peak timing:
  - A peak refreshed at edge E first decrements at edge E+HOLD_CYC+DECAY_CYC.
  - Subsequent decrements follow every DECAY_CYC cycles.
- i_bright, i_mode and i_peak_en changes take effect on o_vol_led one edge later.
- Reset mid-HOLD or mid-DECAY discards all state. No partial decay is retained.

## Test plan
All scenarios use N_LED=8, LVL_W=5, HOLD_CYC=4, DECAY_CYC=2, PWM_W=4, i_bright=15 unless noted.
- Saturation and inversion:
  - invert=1, level=3 → o_vol_led=8'h1F.
  - invert=1, level=12 → 8'h00.
  - invert=0, level=20 → 8'hFF.
  - Each pattern appears one edge after the capture edge.
- Dot mode: invert=0, level=5 → 8'h10; level=0 → 8'h00.
- Peak hold/decay, peak_en=1:
  - Capture 7 then 2 on the next cycle.
  - During the hold window, o_peak=7 and o_vol_led=8'h43.
  - o_peak then steps 6,5,4,3,2 every 2 cycles, then IDLE with o_vol_led=8'h03.
- Re-trigger:
  - During DECAY (peak=5), capture 5 → o_peak stays 5 and hold restarts (4 cycles).
  - Capture 3 → no effect on timing.
- PWM and peak gating:
  - bright=4, level 8, peak_en=0 → 8'hFF exactly 4 of every 16 cycles, else 8'h00.
  - bright=0, level 2, peak 6 → only 8'h20 steady.
- Async reset mid-decay: drop rst_n between edges → o_vol_led=0 and o_peak=0 before the next edge. After release, the first capture behaves as from IDLE.

Source files
------------

// File: rtl/vol_led_meter.sv
// vol_led_meter: volume bar-graph LED driver with peak hold, peak decay
// and PWM dimming of the level bar. All outputs are registered.
module vol_led_meter #(
    parameter int N_LED     = 8,
    parameter int LVL_W     = 5,
    parameter int HOLD_CYC  = 25_000_000,
    parameter int DECAY_CYC = 2_500_000,
    parameter int PWM_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LVL_W-1:0]           i_level,
    input  logic                       i_level_vld,
    input  logic                       i_invert,
    input  logic                       i_mode,
    input  logic                       i_peak_en,
    input  logic [PWM_W-1:0]           i_bright,
    output logic [N_LED-1:0]           o_vol_led,
    output logic [$clog2(N_LED+1)-1:0] o_peak
);

    localparam int PK_W  = $clog2(N_LED + 1);
    localparam int CMAX  = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_RLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DECAY_RLD = CNT_W'(DECAY_CYC - 1);
    localparam logic [LVL_W:0]   N_X       = (LVL_W + 1)'(N_LED);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DECAY
    } state_t;

    state_t             state;
    logic [PK_W-1:0]    cur_lvl;
    logic [PK_W-1:0]    peak;
    logic [CNT_W-1:0]   cnt;
    logic [PWM_W-1:0]   pwm_cnt;

    logic [LVL_W:0]     lvl_x;
    logic [LVL_W:0]     eff_x;
    logic [PK_W-1:0]    eff;
    logic [PK_W-1:0]    cur_nxt;
    logic [PK_W-1:0]    pk_dec;
    logic               pwm_on;
    logic [N_LED-1:0]   lvl_pat;
    logic [N_LED-1:0]   pk_mark;

    // Effective level, saturated to 0..N_LED, computed one bit wider than the input
    always_comb begin
        lvl_x = {1'b0, i_level};
        if (!i_invert) begin
            eff_x = (lvl_x > N_X) ? N_X : lvl_x;
        end else begin
            eff_x = (lvl_x >= N_X) ? '0 : (N_X - lvl_x);
        end
        eff     = PK_W'(eff_x);
        cur_nxt = i_level_vld ? eff : cur_lvl;
        // one-step decay never drops below the (possibly just captured) level
        pk_dec  = (peak > cur_nxt) ? (peak - PK_W'(1)) : cur_nxt;
    end

    // Current level register, loaded on capture strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_lvl <= '0;
        end else begin
            cur_lvl <= cur_nxt;
        end
    end

    // Peak hold/decay FSM sharing one down-counter between HOLD and DECAY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            peak  <= '0;
            cnt   <= '0;
        end else if (!i_peak_en) begin
            state <= IDLE;
            peak  <= cur_nxt;
            cnt   <= '0;
        end else if (i_level_vld && ((eff >= peak) || (state == IDLE))) begin
            // new high refreshes the peak; a lower capture out of IDLE just starts the hold
            if (eff >= peak) begin
                peak <= eff;
            end
            cnt   <= HOLD_RLD;
            state <= HOLD;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        state <= DECAY;
                        cnt   <= DECAY_RLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DECAY: begin
                    if (cnt == '0) begin
                        peak <= pk_dec;
                        cnt  <= DECAY_RLD;
                        if (pk_dec == cur_nxt) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    peak <= cur_nxt;
                end
            endcase
        end
    end

    // Free-running PWM counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Level pattern (bar or dot) and peak marker
    always_comb begin
        pwm_on  = (i_bright == '1) || (pwm_cnt < i_bright);
        lvl_pat = '0;
        pk_mark = '0;
        for (int unsigned k = 0; k < N_LED; k++) begin
            if (i_mode) begin
                lvl_pat[k] = (cur_lvl != '0) && (PK_W'(k) == (cur_lvl - PK_W'(1)));
            end else begin
                lvl_pat[k] = (PK_W'(k) < cur_lvl);
            end
            pk_mark[k] = i_peak_en && (peak > cur_lvl) && (peak != '0)
                         && (PK_W'(k) == (peak - PK_W'(1)));
        end
    end

    // Registered LED pattern: PWM-gated level OR ungated peak marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vol_led <= '0;
        end else begin
            o_vol_led <= (lvl_pat & {N_LED{pwm_on}}) | pk_mark;
        end
    end

    assign o_peak = peak;

endmodule

// File: tb/tb_vol_led_meter.sv
// tb_vol_led_meter: directed-vector bench for vol_led_meter
// (N_LED=8, LVL_W=5, HOLD_CYC=4, DECAY_CYC=2, PWM_W=4).
`timescale 1ns/1ps
module tb_vol_led_meter;

    logic       clk;
    logic       rst_n;
    logic [4:0] i_level;
    logic       i_level_vld;
    logic       i_invert;
    logic       i_mode;
    logic       i_peak_en;
    logic [3:0] i_bright;
    logic [7:0] o_vol_led;
    logic [3:0] o_peak;

    int n_chk  = 0;
    int n_fail = 0;

    vol_led_meter #(
        .N_LED     (8),
        .LVL_W     (5),
        .HOLD_CYC  (4),
        .DECAY_CYC (2),
        .PWM_W     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_level     (i_level),
        .i_level_vld (i_level_vld),
        .i_invert    (i_invert),
        .i_mode      (i_mode),
        .i_peak_en   (i_peak_en),
        .i_bright    (i_bright),
        .o_vol_led   (o_vol_led),
        .o_peak      (o_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic capture(input logic [4:0] lvl, input logic inv);
        i_level     = lvl;
        i_invert    = inv;
        i_level_vld = 1'b1;
        @(posedge clk);
        #1;
        i_level_vld = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int on_cnt;
        int other_cnt;
        rst_n       = 1'b0;
        i_level     = '0;
        i_level_vld = 1'b0;
        i_invert    = 1'b0;
        i_mode      = 1'b0;
        i_peak_en   = 1'b0;
        i_bright    = 4'hF;

        // reset state before any clock edge
        #2;
        check("rst_led", 32'(o_vol_led), 32'h00);
        check("rst_peak", 32'(o_peak), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // saturation and inversion, bar mode, no peak
        capture(5'd3, 1'b1);
        check("inv3_latency", 32'(o_vol_led), 32'h00);
        tick(1);
        check("inv3", 32'(o_vol_led), 32'h1F);
        capture(5'd12, 1'b1);
        check("inv12_latency", 32'(o_vol_led), 32'h1F);
        tick(1);
        check("inv12", 32'(o_vol_led), 32'h00);
        capture(5'd20, 1'b0);
        tick(1);
        check("sat20", 32'(o_vol_led), 32'hFF);
        capture(5'd8, 1'b1);
        tick(1);
        check("inv8", 32'(o_vol_led), 32'h00);
        capture(5'd0, 1'b1);
        tick(1);
        check("inv0", 32'(o_vol_led), 32'hFF);
        capture(5'd7, 1'b0);
        tick(1);
        check("bar7", 32'(o_vol_led), 32'h7F);

        // dot mode
        i_mode = 1'b1;
        capture(5'd5, 1'b0);
        tick(1);
        check("dot5", 32'(o_vol_led), 32'h10);
        capture(5'd0, 1'b0);
        tick(1);
        check("dot0", 32'(o_vol_led), 32'h00);
        capture(5'd8, 1'b0);
        tick(1);
        check("dot8", 32'(o_vol_led), 32'h80);
        i_mode = 1'b0;
        tick(1);
        check("mode_to_bar", 32'(o_vol_led), 32'hFF);

        // peak hold and decay
        do_reset();
        i_peak_en = 1'b1;
        capture(5'd7, 1'b0);
        check("pk_cap7", 32'(o_peak), 32'd7);
        capture(5'd2, 1'b0);
        check("pk_hold_e1", 32'(o_peak), 32'd7);
        tick(1);
        check("pk_led_e2", 32'(o_vol_led), 32'h43);
        tick(3);
        check("pk_hold_e5", 32'(o_peak), 32'd7);
        check("pk_led_e5", 32'(o_vol_led), 32'h43);
        tick(1);
        check("pk_dec_e6", 32'(o_peak), 32'd6);
        tick(1);
        check("pk_led_e7", 32'(o_vol_led), 32'h23);
        tick(1);
        check("pk_dec_e8", 32'(o_peak), 32'd5);
        for (int p = 4; p >= 2; p--) begin
            tick(2);
            check("pk_dec_step", 32'(o_peak), 32'(p));
        end
        tick(1);
        check("pk_idle_led", 32'(o_vol_led), 32'h03);
        tick(4);
        check("pk_idle_peak", 32'(o_peak), 32'd2);
        check("pk_idle_led2", 32'(o_vol_led), 32'h03);

        // re-trigger during decay
        do_reset();
        capture(5'd7, 1'b0);
        capture(5'd2, 1'b0);
        tick(7);
        check("rt_e8", 32'(o_peak), 32'd5);
        capture(5'd5, 1'b0);
        check("rt_cap5", 32'(o_peak), 32'd5);
        capture(5'd3, 1'b0);
        check("rt_cap3", 32'(o_peak), 32'd5);
        tick(4);
        check("rt_hold_e14", 32'(o_peak), 32'd5);
        tick(1);
        check("rt_dec_e15", 32'(o_peak), 32'd4);
        tick(1);
        check("rt_e16", 32'(o_peak), 32'd4);
        tick(1);
        check("rt_e17", 32'(o_peak), 32'd3);
        tick(1);
        check("rt_idle_led", 32'(o_vol_led), 32'h07);

        // PWM duty with peak disabled
        do_reset();
        i_peak_en = 1'b0;
        i_bright  = 4'd4;
        capture(5'd8, 1'b0);
        tick(1);
        on_cnt    = 0;
        other_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (o_vol_led == 8'hFF) on_cnt++;
            else if (o_vol_led != 8'h00) other_cnt++;
            tick(1);
        end
        check("pwm_on_count", 32'(on_cnt), 32'd4);
        check("pwm_other", 32'(other_cnt), 32'd0);

        // peak marker is not dimmed
        do_reset();
        i_peak_en = 1'b1;
        i_bright  = 4'd0;
        capture(5'd6, 1'b0);
        capture(5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("dim_peak_led", 32'(o_vol_led), 32'h20);
        end
        check("dim_peak_val", 32'(o_peak), 32'd6);

        // async reset mid-decay
        do_reset();
        i_bright = 4'hF;
        capture(5'd7, 1'b0);
        capture(5'd2, 1'b0);
        tick(5);
        check("ar_pre_peak", 32'(o_peak), 32'd6);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_led", 32'(o_vol_led), 32'h00);
        check("ar_peak", 32'(o_peak), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("ar_post_peak", 32'(o_peak), 32'd0);
        capture(5'd3, 1'b0);
        check("ar_cap3", 32'(o_peak), 32'd3);
        tick(1);
        check("ar_led3", 32'(o_vol_led), 32'h07);
        tick(6);
        check("ar_settle", 32'(o_peak), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
